fp_adder: RTL and testbench

//   IEEE-754 binary32 adder: sum = a + b, round-to-nearest-even.

---
 rtl/fp32_pkg.sv | 18 +
 rtl/fp_adder_if.sv | 11 +
 rtl/fp_lzc24.sv | 16 +
 rtl/fp_adder.sv | 101 ++++++++++
 tb/tb_fp_adder.sv | 108 ++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 format constants and field layout for the FP datapath.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_adder_if.sv
// Operand/result bundle for the binary32 adder; master drives operands, slave returns the sum.
interface fp_adder_if;

    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;

    modport master (output a, output b, input sum);
    modport slave  (input a, input b, output sum);

endinterface

// File: rtl/fp_lzc24.sv
// 24-bit leading-zero counter; an all-zero input reports 24.
module fp_lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    always_comb begin
        // NOTE: give every combinational output a default before any conditional write, so no latch is inferred.
        count = 5'd24;
        // Scanning upward lets the highest set bit win.
        for (int i = 0; i < 24; i++) begin
            if (value[i]) count = 5'(23 - i);
        end
    end

endmodule

// File: rtl/fp_adder.sv
// IEEE-754 binary32 adder, round-to-nearest-even, one registered output stage.
module fp_adder
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    fp32_t fa, fb, p, s;
    logic        a_big, eff_sub;
    logic [7:0]  ep, es, diff, lim, sh;
    logic [23:0] mp, ms;
    logic [49:0] shifted;
    logic [26:0] mp27, ms27, norm;
    logic [27:0] raw;
    logic [4:0]  lz;
    logic [9:0]  exp_n, exp_pre, exp_fin;
    logic        round_up;
    logic [24:0] mant25;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic [31:0] res;

    assign fa = a;
    assign fb = b;

    // Primary operand carries the larger magnitude, so subtraction never goes negative.
    assign a_big = {fa.exp, fa.frac} >= {fb.exp, fb.frac};
    assign p     = a_big ? fa : fb;
    assign s     = a_big ? fb : fa;

    assign ep   = (p.exp == 8'd0) ? 8'd1 : p.exp;
    assign es   = (s.exp == 8'd0) ? 8'd1 : s.exp;
    assign mp   = {p.exp != 8'd0, p.frac};
    assign ms   = {s.exp != 8'd0, s.frac};
    assign diff = ep - es;

    // Aligned layout is {significand[23:0], guard, round, sticky}.
    assign shifted = {ms, 26'd0} >> diff;
    assign ms27    = (diff >= 8'd26) ? {26'd0, |ms} : {shifted[49:24], |shifted[23:0]};
    assign mp27    = {mp, 3'b000};

    assign eff_sub = p.sign ^ s.sign;
    assign raw     = eff_sub ? ({1'b0, mp27} - {1'b0, ms27}) : ({1'b0, mp27} + {1'b0, ms27});

    fp_lzc24 u_lzc (
        .value (raw[26:3]),
        .count (lz)
    );

    // Left shift is clamped at exponent 1; whatever is left unnormalized becomes subnormal.
    assign lim = ep - 8'd1;
    assign sh  = ({3'd0, lz} < lim) ? {3'd0, lz} : lim;

    always_comb begin
        norm  = '0;
        exp_n = '0;
        if (raw[27]) begin
            norm  = {raw[27:2], raw[1] | raw[0]};
            exp_n = {2'b00, ep} + 10'd1;
        end else begin
            norm  = raw[26:0] << sh;
            exp_n = {2'b00, ep - sh};
        end
    end

    assign exp_pre  = norm[26] ? exp_n : 10'd0;
    assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign mant25   = {1'b0, norm[26:3]} + {24'd0, round_up};
    // Rounding carry either bumps a normal exponent or promotes a subnormal to min-normal.
    assign exp_fin  = exp_pre + {9'd0, mant25[24] | ((exp_pre == 10'd0) & mant25[23])};

    assign nan_a = (fa.exp == 8'hFF) && (fa.frac != '0);
    assign nan_b = (fb.exp == 8'hFF) && (fb.frac != '0);
    assign inf_a = (fa.exp == 8'hFF) && (fa.frac == '0);
    assign inf_b = (fb.exp == 8'hFF) && (fb.frac == '0);

    always_comb begin
        res = {p.sign, exp_fin[7:0], mant25[22:0]};
        if (nan_a || nan_b || (inf_a && inf_b && (fa.sign != fb.sign))) begin
            res = QNAN;
        end else if (inf_a) begin
            res = a;
        end else if (inf_b) begin
            res = b;
        end else if (mant25 == 25'd0) begin
            res = {fa.sign & fb.sign, 31'd0};
        end else if (exp_fin >= 10'd255) begin
            res = p.sign ? NEG_INF : POS_INF;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum <= '0;
        else        sum <= res;
    end

endmodule

// File: tb/tb_fp_adder.sv
// Directed-vector bench for fp_adder: stimulus pushes expected sums, a monitor pops and compares.
module tb_fp_adder;
    import fp32_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_adder_if bus ();

    fp_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (bus.a),
        .b     (bus.b),
        .sum   (bus.sum)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  failures = 0;

    localparam int N = 16;
    localparam logic [31:0] VA [N] = '{
        32'h3F800000, 32'h42C88000, 32'h00000003, 32'h007FFFFF,
        32'h007FFFFF, 32'h007FFFFF, 32'h7E8F0FFF, 32'h700F0FFF,
        32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000,
        32'h00000000, 32'h7F800000, 32'h7F7FFFFF, 32'h7FC00001};
    localparam logic [31:0] VB [N] = '{
        32'h3F800000, 32'h3F9E6000, 32'h00000001, 32'h00000001,
        32'h00405A5A, 32'h00C05A5A, 32'hFDF5FFFA, 32'h80C05A5A,
        32'hFDF5FFFA, 32'h00000001, 32'h00000000, 32'h80000000,
        32'h7F003400, 32'hFF800000, 32'h7F7FFFFF, 32'h3F800000};
    localparam logic [31:0] VE [N] = '{
        32'h40000000, 32'h42CAF980, 32'h00000004, 32'h00800000,
        32'h00C05A59, 32'h01202D2C, 32'h7E232001, 32'h700F0FFF,
        32'hFDF5FFFA, 32'h00000001, 32'h00000000, 32'h80000000,
        32'h7F003400, 32'h7FC00000, 32'h7F800000, 32'h7FC00000};
    string VN [N] = '{
        "one_plus_one", "normal_mix", "sub_sub", "sub_to_min_normal",
        "sub_sum_normal", "sub_norm_rne_tie", "cancel_shift", "far_sticky_sub",
        "negzero_plus_x", "zero_plus_denorm", "negzero_plus_zero", "negzero_plus_negzero",
        "zero_plus_big", "inf_minus_inf", "overflow_to_inf", "nan_in"};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: one result per clock, one clock after the operands were applied.
    always begin
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            check(e.name, bus.sum, e.exp);
        end
    end

    initial begin
        int budget;
        bus.a = '0;
        bus.b = '0;
        rst_n = 1'b0;
        #12;
        check("reset_value", bus.sum, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus.a = VA[i];
            bus.b = VB[i];
            sb_q.push_back('{VN[i], VE[i]});
        end

        budget = 0;
        while (sb_q.size() > 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending %0d expected 0", sb_q.size());
        end

        // Assert reset between edges; the output must clear without waiting for a clock.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", bus.sum, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
